ahb_multi_ch_bridge: RTL and testbench
======================================

// Module: ahb_multi_ch_bridge
// PURPOSE
//  AHB-Lite slave bridge fanning one address window out to NUM_CH peripheral register ports.
//  Generalises the single-port bridge: parametrised data width, depth and channel count, read strobe, peripheral wait states (p_ready),
//  peripheral error, alignment/size checks and the two-cycle AHB ERROR response. Sits between the AHB interconnect and register-file peripherals.
// PARAMETERS
//  DATA_W      32   data bus width in bits (32 or 64); BYTE_W=$clog2(DATA_W/8)
//  ADDR_W      32   AHB address width
//  NUM_WORDS   64   registers per channel; OFF_W=$clog2(NUM_WORDS)
//  NUM_CH      4    peripheral channels (>=1); CH_W=$clog2(NUM_CH), 0 when NUM_CH=1
//  TIMEOUT_CYC 255  max p_ready wait cycles (used only with AHB_BRIDGE_TIMEOUT_EN)
// PORTS
//  h_clk      in  1                  clock (all logic posedge)
//  h_resetn   in  1                  async active-low reset
//  h_sel      in  1                  slave select from decoder
//  h_addr     in  ADDR_W             address-phase address
//  h_trans    in  2                  IDLE/BUSY/NONSEQ/SEQ
//  h_write    in  1                  1=write
//  h_size     in  3                  transfer size
//  h_burst    in  3                  burst type (incrementing only; WRAP treated as INCR)
//  h_wdata    in  DATA_W             data-phase write data
//  h_wstrb    in  DATA_W/8           write byte strobes
//  h_ready_in in  1                  bus HREADY (previous transfer done)
//  h_rdata    out DATA_W             read data
//  h_ready    out 1                  HREADYOUT
//  h_resp     out 1                  0=OKAY 1=ERROR
//  base_addr  in  ADDR_W-BYTE_W-OFF_W-CH_W  window base compared to upper h_addr bits
//  p_sel      out NUM_CH             one-hot channel select (data phase)
//  p_offset   out OFF_W              word offset = addr[BYTE_W+:OFF_W]
//  p_wen      out 1                  write strobe;  p_ren out 1: read strobe
//  p_wdata    out DATA_W             = h_wdata;  p_strb out DATA_W/8: h_wstrb & size/addr mask
//  p_rdata    in  NUM_CH*DATA_W      per-channel read data, channel c at [c*DATA_W+:DATA_W]
//  p_ready    in  NUM_CH             per-channel access complete;  p_slverr in NUM_CH: per-channel error, valid with p_ready
// BEHAVIOUR
//  Reset: state IDLE; h_ready=1, h_resp=0, h_rdata=0, p_sel=0, p_wen=p_ren=0, p_strb=0, p_offset=0.
//  Address phase accepted when h_sel & h_ready_in & h_ready & h_trans[1]; regs capture addr, write, size, wstrb mask.
//  IDLE/BUSY or h_sel=0: no capture; next data phase zero-wait OKAY. Channel = addr[BYTE_W+OFF_W+:CH_W].
//  Check at capture (err flag): addr upper bits != base_addr, 2**h_size > DATA_W/8, or addr not aligned to size.
//  FSM: IDLE -> ACCESS (valid, no err) | ERR1 (valid, err). ACCESS: p_sel[ch]=1 and p_wen/p_ren held; h_ready=0 while p_ready[ch]=0.
//   ACCESS with p_ready[ch]=1: p_slverr[ch]=0 -> h_ready=1, h_resp=0, h_rdata=p_rdata[ch] (reads), pipeline may accept next address
//   this cycle (-> ACCESS/ERR1/IDLE); p_slverr[ch]=1 -> ERR1 (no data returned).
//  ERR1: h_ready=0, h_resp=1, no p_* strobes. ERR2: h_ready=1, h_resp=1; next address phase may be accepted -> ACCESS/ERR1/IDLE.
//  Peripheral writes never happen for an errored transfer; latency min 1 data-phase cycle (p_ready tied 1).
//  p_strb: byte lanes [addr[BYTE_W-1:0] +: 2**size] ANDed with h_wstrb; reads force p_strb=0. h_rdata=0 outside read completion.
//  Reset mid-ACCESS: immediately back to reset values; pending transfer dropped.
// CONFIGURATION
//  AHB_BRIDGE_TIMEOUT_EN defined: 8-bit-min counter counts ACCESS cycles with p_ready[ch]=0; reaching TIMEOUT_CYC -> ERR1, p_sel dropped;
//   counter clears on every state change. Undefined: no counter, ACCESS waits indefinitely; TIMEOUT_CYC ignored.
// STRUCTURE
//  ahb_bridge_pkg: htrans_t (IDLE/BUSY/NONSEQ/SEQ), hsize_t, hresp constants, bridge_state_t (IDLE/ACCESS/ERR1/ERR2).
//  Sub-module ahb_bridge_strb_gen (combinational): addr low bits + size + wstrb -> lane mask and size/align error.
// TESTING
//  1 NUM_CH=4, p_ready=1: NONSEQ write 0x1234_5678 to base|ch2|off5, size=2 -> p_sel=4'b0100, p_offset=5, p_strb=4'hF, OKAY in 1 cycle.
//  2 Read ch1 with p_ready low 3 cycles -> h_ready=0 for 3 cycles, then h_rdata=p_rdata[63:32], OKAY; back-to-back SEQ accepted same cycle.
//  3 Byte write size=0 addr[1:0]=2'b10, h_wstrb=4'hF -> p_strb=4'b0100; halfword at addr[1:0]=2'b01 -> ERR1,ERR2, p_wen never 1.
//  4 Address with wrong base -> ERROR two-cycle (h_ready 0 then 1, h_resp=1 both); p_slverr=1 on ch0 read -> same ERROR, h_rdata=0.
//  5 IDLE/BUSY transfers and h_sel=0 -> h_ready=1, h_resp=0, no p_sel; h_resetn low mid-ACCESS -> all outputs to reset values.
//  6 AHB_BRIDGE_TIMEOUT_EN, TIMEOUT_CYC=4, p_ready stuck 0 -> ERR1 after 4 wait cycles; without macro stays waiting 100+ cycles.

Source files
------------

// File: rtl/ahb_bridge_pkg.sv
// Shared types and constants for the multi-channel AHB-Lite register bridge.
package ahb_bridge_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [2:0] {
        HSIZE_BYTE  = 3'd0,
        HSIZE_HALF  = 3'd1,
        HSIZE_WORD  = 3'd2,
        HSIZE_DWORD = 3'd3,
        HSIZE_4W    = 3'd4,
        HSIZE_8W    = 3'd5,
        HSIZE_16W   = 3'd6,
        HSIZE_32W   = 3'd7
    } hsize_t;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef logic [1:0] bridge_state_t;

    localparam bridge_state_t ST_IDLE   = 2'd0;
    localparam bridge_state_t ST_ACCESS = 2'd1;
    localparam bridge_state_t ST_ERR1   = 2'd2;
    localparam bridge_state_t ST_ERR2   = 2'd3;

    function automatic int unsigned size_bytes(input logic [2:0] size);
        return 32'd1 << size;
    endfunction

endpackage

// File: rtl/ahb_bridge_strb_gen.sv
// Byte-lane mask for an AHB transfer plus size/alignment legality check.
module ahb_bridge_strb_gen
    import ahb_bridge_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    localparam int unsigned STRB_W = DATA_W / 8,
    localparam int unsigned BYTE_W = $clog2(STRB_W)
) (
    input  logic [BYTE_W-1:0] addr_lo,
    input  logic [2:0]        size,
    input  logic [STRB_W-1:0] wstrb,
    output logic [STRB_W-1:0] strb,
    output logic              err
);

    int unsigned nbytes;
    int unsigned lo;

    always_comb begin
        nbytes = size_bytes(size);
        lo     = 32'(addr_lo);
        err    = (nbytes > STRB_W) || ((lo & (nbytes - 32'd1)) != 32'd0);
        strb   = '0;
        for (int unsigned i = 0; i < STRB_W; i++) begin
            strb[i] = wstrb[i] && (i >= lo) && (i < lo + nbytes);
        end
    end

endmodule

// File: rtl/ahb_multi_ch_bridge.sv
// AHB-Lite slave fanning one address window out to NUM_CH register ports.
// Optional p_ready timeout is enabled by defining AHB_BRIDGE_TIMEOUT_EN.
module ahb_multi_ch_bridge
    import ahb_bridge_pkg::*;
#(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned NUM_WORDS   = 64,
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned TIMEOUT_CYC = 255,
    localparam int unsigned STRB_W = DATA_W / 8,
    localparam int unsigned BYTE_W = $clog2(STRB_W),
    localparam int unsigned OFF_W  = $clog2(NUM_WORDS),
    localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 0,
    localparam int unsigned BASE_W = ADDR_W - BYTE_W - OFF_W - CH_W
) (
    input  logic                     h_clk,
    input  logic                     h_resetn,
    input  logic                     h_sel,
    input  logic [ADDR_W-1:0]        h_addr,
    input  logic [1:0]               h_trans,
    input  logic                     h_write,
    input  logic [2:0]               h_size,
    input  logic [2:0]               h_burst,
    input  logic [DATA_W-1:0]        h_wdata,
    input  logic [STRB_W-1:0]        h_wstrb,
    input  logic                     h_ready_in,
    output logic [DATA_W-1:0]        h_rdata,
    output logic                     h_ready,
    output logic                     h_resp,
    input  logic [BASE_W-1:0]        base_addr,
    output logic [NUM_CH-1:0]        p_sel,
    output logic [OFF_W-1:0]         p_offset,
    output logic                     p_wen,
    output logic                     p_ren,
    output logic [DATA_W-1:0]        p_wdata,
    output logic [STRB_W-1:0]        p_strb,
    input  logic [NUM_CH*DATA_W-1:0] p_rdata,
    input  logic [NUM_CH-1:0]        p_ready,
    input  logic [NUM_CH-1:0]        p_slverr
);

    localparam int unsigned CH_RW   = (CH_W > 0) ? CH_W : 1;
    localparam int unsigned BASE_LO = BYTE_W + OFF_W + CH_W;

    bridge_state_t     state_q, state_d;
    logic [CH_RW-1:0]  ch_q, ch_in;
    logic [OFF_W-1:0]  offset_q;
    logic              write_q;
    logic [STRB_W-1:0] lane_q, lane_in;
    logic              size_err, cap_err, addr_valid, accept, done;
    logic              ch_ready, ch_err;
    logic [DATA_W-1:0] ch_rdata;
    htrans_t           trans;

    // Bursts need no special handling: every beat carries its own address.
    logic unused_burst;
    assign unused_burst = ^h_burst;

    if (CH_W > 0) begin : g_ch
        assign ch_in = h_addr[BYTE_W+OFF_W +: CH_W];
    end else begin : g_no_ch
        assign ch_in = '0;
    end

    ahb_bridge_strb_gen #(
        .DATA_W (DATA_W)
    ) u_strb_gen (
        .addr_lo (h_addr[BYTE_W-1:0]),
        .size    (h_size),
        .wstrb   ({STRB_W{1'b1}}),
        .strb    (lane_in),
        .err     (size_err)
    );

    assign trans      = htrans_t'(h_trans);
    assign addr_valid = h_sel && h_ready_in &&
                        (trans == HTRANS_NONSEQ || trans == HTRANS_SEQ);
    assign cap_err    = size_err || (h_addr[ADDR_W-1:BASE_LO] != base_addr) ||
                        (32'(ch_in) >= NUM_CH);
    assign accept     = done && addr_valid;

    assign ch_ready = p_ready[ch_q];
    assign ch_err   = p_slverr[ch_q];
    assign ch_rdata = p_rdata[ch_q*DATA_W +: DATA_W];
    assign p_offset = offset_q;
    assign p_wdata  = h_wdata;

`ifdef AHB_BRIDGE_TIMEOUT_EN
    localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYC;
`endif

    always_comb begin
        state_d = state_q;
        h_ready = 1'b1;
        h_resp  = HRESP_OKAY;
        h_rdata = '0;
        p_sel   = '0;
        p_wen   = 1'b0;
        p_ren   = 1'b0;
        p_strb  = '0;
        done    = 1'b0;
`ifdef AHB_BRIDGE_TIMEOUT_EN
        cnt_d   = '0;
`endif
        case (state_q)
            ST_IDLE: done = 1'b1;
            ST_ACCESS: begin
                p_sel[ch_q] = 1'b1;
                p_wen       = write_q;
                p_ren       = !write_q;
                if (write_q) p_strb = lane_q & h_wstrb;
                if (ch_ready) begin
                    if (ch_err) begin
                        h_ready = 1'b0;
                        state_d = ST_ERR1;
                    end else begin
                        done = 1'b1;
                        if (!write_q) h_rdata = ch_rdata;
                    end
                end else begin
                    h_ready = 1'b0;
`ifdef AHB_BRIDGE_TIMEOUT_EN
                    if (32'(cnt_q) + 32'd1 >= TIMEOUT_CYC) begin
                        state_d = ST_ERR1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
`endif
                end
            end
            ST_ERR1: begin
                h_ready = 1'b0;
                h_resp  = HRESP_ERROR;
                state_d = ST_ERR2;
            end
            ST_ERR2: begin
                h_resp = HRESP_ERROR;
                done   = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
        // Completion cycles double as the next address phase.
        if (done) state_d = accept ? (cap_err ? ST_ERR1 : ST_ACCESS) : ST_IDLE;
    end

    always_ff @(posedge h_clk or negedge h_resetn) begin
        if (!h_resetn) begin
            state_q  <= ST_IDLE;
            ch_q     <= '0;
            offset_q <= '0;
            write_q  <= 1'b0;
            lane_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                ch_q     <= ch_in;
                offset_q <= h_addr[BYTE_W +: OFF_W];
                write_q  <= h_write;
                lane_q   <= lane_in;
            end
        end
    end

`ifdef AHB_BRIDGE_TIMEOUT_EN
    always_ff @(posedge h_clk or negedge h_resetn) begin
        if (!h_resetn) cnt_q <= '0;
        else           cnt_q <= cnt_d;
    end
`endif

endmodule

// File: tb/tb_ahb_multi_ch_bridge.sv
// Directed self-checking bench for ahb_multi_ch_bridge (4 channels, 32-bit data).
module tb_ahb_multi_ch_bridge;
    import ahb_bridge_pkg::*;

    localparam int unsigned DATA_W      = 32;
    localparam int unsigned ADDR_W      = 32;
    localparam int unsigned NUM_WORDS   = 64;
    localparam int unsigned NUM_CH      = 4;
    localparam int unsigned TIMEOUT_CYC = 4;
    localparam logic [21:0] BASE        = 22'h0002A5;

    logic                     h_clk = 1'b0;
    logic                     h_resetn = 1'b0;
    logic                     h_sel, h_write, h_ready_in, h_ready, h_resp;
    logic [ADDR_W-1:0]        h_addr;
    logic [1:0]               h_trans;
    logic [2:0]               h_size, h_burst;
    logic [DATA_W-1:0]        h_wdata, h_rdata, p_wdata;
    logic [3:0]               h_wstrb, p_strb;
    logic [3:0]               p_sel, p_ready, p_slverr;
    logic [5:0]               p_offset;
    logic                     p_wen, p_ren;
    logic [NUM_CH*DATA_W-1:0] p_rdata;

    int checks = 0;
    int failures = 0;
    int waits;

    always #5 h_clk = ~h_clk;

    ahb_multi_ch_bridge #(
        .DATA_W      (DATA_W),
        .ADDR_W      (ADDR_W),
        .NUM_WORDS   (NUM_WORDS),
        .NUM_CH      (NUM_CH),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .h_clk      (h_clk),
        .h_resetn   (h_resetn),
        .h_sel      (h_sel),
        .h_addr     (h_addr),
        .h_trans    (h_trans),
        .h_write    (h_write),
        .h_size     (h_size),
        .h_burst    (h_burst),
        .h_wdata    (h_wdata),
        .h_wstrb    (h_wstrb),
        .h_ready_in (h_ready_in),
        .h_rdata    (h_rdata),
        .h_ready    (h_ready),
        .h_resp     (h_resp),
        .base_addr  (BASE),
        .p_sel      (p_sel),
        .p_offset   (p_offset),
        .p_wen      (p_wen),
        .p_ren      (p_ren),
        .p_wdata    (p_wdata),
        .p_strb     (p_strb),
        .p_rdata    (p_rdata),
        .p_ready    (p_ready),
        .p_slverr   (p_slverr)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk_addr(input logic [1:0] ch, input logic [5:0] off,
                                            input logic [1:0] lo);
        return {BASE, ch, off, lo};
    endfunction

    task automatic cyc();
        @(posedge h_clk);
        #1;
    endtask

    task automatic mid();
        @(negedge h_clk);
    endtask

    task automatic drive_addr(input logic sel, input logic [1:0] trans, input logic wr,
                              input logic [2:0] size, input logic [31:0] addr);
        h_sel   = sel;
        h_trans = trans;
        h_write = wr;
        h_size  = size;
        h_addr  = addr;
    endtask

    task automatic drive_idle();
        drive_addr(1'b0, HTRANS_IDLE, 1'b0, 3'd2, 32'h0);
    endtask

    task automatic check_reset(input string tag);
        check_eq({tag, "_ready"}, h_ready, 1);
        check_eq({tag, "_quiet"}, {h_resp, h_rdata, p_sel, p_wen, p_ren, p_strb, p_offset}, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "bench time limit");
    end

    initial begin
        drive_idle();
        h_wdata    = '0;
        h_wstrb    = 4'hF;
        h_burst    = 3'd0;
        h_ready_in = 1'b1;
        p_ready    = 4'hF;
        p_slverr   = 4'h0;
        p_rdata    = {32'hD3D3_3333, 32'hC2C2_2222, 32'hB1B1_1111, 32'hA0A0_0000};
        repeat (2) cyc();
        mid();
        check_reset("reset");
        h_resetn = 1'b1;

        // Word write to ch2 offset 5, zero wait states
        cyc(); drive_addr(1'b1, HTRANS_NONSEQ, 1'b1, 3'd2, mk_addr(2'd2, 6'd5, 2'd0));
        mid(); check_eq("t1_addr_ready", h_ready, 1);
        cyc(); drive_idle(); h_wdata = 32'h1234_5678;
        mid();
        check_eq("t1_psel", p_sel, 4'b0100);
        check_eq("t1_offset", p_offset, 5);
        check_eq("t1_strb", p_strb, 4'hF);
        check_eq("t1_wen_ren", {p_wen, p_ren}, 2'b10);
        check_eq("t1_wdata", p_wdata, 32'h1234_5678);
        check_eq("t1_ready_resp", {h_ready, h_resp}, 2'b10);
        cyc(); mid();
        check_eq("t1_after", {p_sel, p_wen}, 0);

        // Read ch1 with three wait states, SEQ follow-up accepted on completion
        cyc(); drive_addr(1'b1, HTRANS_NONSEQ, 1'b0, 3'd2, mk_addr(2'd1, 6'd3, 2'd0));
        p_ready = 4'b1101;
        cyc(); drive_addr(1'b1, HTRANS_SEQ, 1'b0, 3'd2, mk_addr(2'd1, 6'd4, 2'd0));
        for (int i = 0; i < 3; i++) begin
            if (i > 0) cyc();
            mid();
            check_eq($sformatf("t2_wait%0d_ready", i), h_ready, 0);
            check_eq($sformatf("t2_wait%0d_sel", i), {p_sel, p_ren, h_rdata}, {4'b0010, 1'b1, 32'h0});
        end
        cyc(); p_ready = 4'hF;
        mid();
        check_eq("t2_done", {h_ready, h_resp}, 2'b10);
        check_eq("t2_rdata", h_rdata, 32'hB1B1_1111);
        cyc(); drive_idle();
        mid();
        check_eq("t2_seq_sel", {p_sel, p_offset, p_ren}, {4'b0010, 6'd4, 1'b1});
        check_eq("t2_seq_rdata", {h_ready, h_rdata}, {1'b1, 32'hB1B1_1111});
        cyc(); mid();
        check_eq("t2_after", {p_sel, h_rdata}, 0);

        // Byte write lane 2, then misaligned halfword
        cyc(); drive_addr(1'b1, HTRANS_NONSEQ, 1'b1, 3'd0, mk_addr(2'd0, 6'd1, 2'd2));
        cyc(); drive_addr(1'b1, HTRANS_NONSEQ, 1'b1, 3'd1, mk_addr(2'd0, 6'd2, 2'd1));
        h_wdata = 32'h00AB_0000;
        mid();
        check_eq("t3_byte_strb", p_strb, 4'b0100);
        check_eq("t3_byte_wen", {p_wen, p_sel, p_offset, h_ready}, {1'b1, 4'b0001, 6'd1, 1'b1});
        cyc(); drive_idle();
        mid();
        check_eq("t3_err1", {h_ready, h_resp}, 2'b01);
        check_eq("t3_err1_quiet", {p_wen, p_sel, p_strb}, 0);
        cyc(); mid();
        check_eq("t3_err2", {h_ready, h_resp, p_wen}, 3'b110);
        cyc(); mid();
        check_eq("t3_after", {h_ready, h_resp}, 2'b10);

        // Wrong base, then peripheral error on a ch0 read
        cyc(); drive_addr(1'b1, HTRANS_NONSEQ, 1'b1, 3'd2, {BASE + 22'd1, 10'd0});
        cyc(); drive_idle();
        mid(); check_eq("t4_base_err1", {h_ready, h_resp, p_sel}, {2'b01, 4'b0000});
        cyc(); mid(); check_eq("t4_base_err2", {h_ready, h_resp}, 2'b11);
        cyc(); drive_addr(1'b1, HTRANS_NONSEQ, 1'b0, 3'd2, mk_addr(2'd0, 6'd7, 2'd0));
        p_slverr = 4'b0001;
        cyc(); drive_idle();
        mid();
        check_eq("t4_slv_access", {h_ready, h_resp, p_sel, h_rdata}, {2'b00, 4'b0001, 32'h0});
        cyc(); mid();
        check_eq("t4_slv_err1", {h_ready, h_resp, h_rdata}, {2'b01, 32'h0});
        cyc(); p_slverr = 4'h0;
        mid();
        check_eq("t4_slv_err2", {h_ready, h_resp, h_rdata}, {2'b11, 32'h0});
        cyc(); mid();
        check_eq("t4_after", {h_ready, h_resp}, 2'b10);

        // BUSY, unselected and stalled-bus address phases are ignored
        cyc(); drive_addr(1'b1, HTRANS_BUSY, 1'b1, 3'd2, mk_addr(2'd3, 6'd0, 2'd0));
        cyc(); drive_addr(1'b0, HTRANS_NONSEQ, 1'b1, 3'd2, mk_addr(2'd3, 6'd1, 2'd0));
        mid(); check_eq("t5_busy", {h_ready, h_resp, p_sel}, {2'b10, 4'b0000});
        cyc(); drive_addr(1'b1, HTRANS_NONSEQ, 1'b1, 3'd2, mk_addr(2'd3, 6'd2, 2'd0));
        h_ready_in = 1'b0;
        mid(); check_eq("t5_nosel", {h_ready, h_resp, p_sel, p_wen}, {2'b10, 5'b0});
        cyc(); drive_idle(); h_ready_in = 1'b1;
        mid(); check_eq("t5_noready_in", {h_ready, p_sel, p_wen}, {1'b1, 5'b0});

        // Reset asserted while a ch3 read is waiting
        cyc(); drive_addr(1'b1, HTRANS_NONSEQ, 1'b0, 3'd2, mk_addr(2'd3, 6'd9, 2'd0));
        p_ready = 4'b0111;
        cyc(); drive_idle();
        mid(); check_eq("t5_pre_reset", {h_ready, p_sel, p_offset}, {1'b0, 4'b1000, 6'd9});
        h_resetn = 1'b0;
        #1;
        check_reset("t5_reset_mid");
        #1 h_resetn = 1'b1;
        cyc(); mid();
        check_eq("t5_post_reset", {h_ready, p_sel, p_ren}, {1'b1, 5'b0});
        p_ready = 4'hF;

        // ch2 read with p_ready stuck low
        cyc(); drive_addr(1'b1, HTRANS_NONSEQ, 1'b0, 3'd2, mk_addr(2'd2, 6'd6, 2'd0));
        p_ready = 4'b1011;
        cyc(); drive_idle();
`ifdef AHB_BRIDGE_TIMEOUT_EN
        for (int i = 0; i < 4; i++) begin
            if (i > 0) cyc();
            mid();
            check_eq($sformatf("t6_wait%0d", i), {h_ready, h_resp, p_sel}, {2'b00, 4'b0100});
        end
        cyc(); mid();
        check_eq("t6_timeout_err1", {h_ready, h_resp, p_sel}, {2'b01, 4'b0000});
        cyc(); mid();
        check_eq("t6_timeout_err2", {h_ready, h_resp}, 2'b11);
        p_ready = 4'hF;
`else
        waits = 0;
        for (int i = 0; i < 120; i++) begin
            if (i > 0) cyc();
            mid();
            if (h_ready === 1'b0 && h_resp === 1'b0 && p_sel === 4'b0100) waits++;
        end
        check_eq("t6_waits", waits, 120);
        cyc(); p_ready = 4'hF;
        mid();
        check_eq("t6_late_done", {h_ready, h_resp, h_rdata}, {2'b10, 32'hC2C2_2222});
`endif
        cyc(); mid();
        check_eq("t6_after", {h_ready, p_sel}, {1'b1, 4'b0000});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
